// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: ALU control codes for the divide ops, divider FSM states and width.
package cpu_defs_pkg;

   localparam logic [5:0] ALU_DIV   = 6'b011100;
   localparam logic [5:0] ALU_DIVU  = 6'b001100;
   localparam int         DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_if.sv
// Divider request/response bundle between execute-stage control (master) and div_unit (slave).
interface div_if #(
   parameter int WIDTH = 32
);
   logic                 start;
   logic                 signed_div;
   logic                 cancel;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 div_ready;
   logic [2*WIDTH-1:0]   result;

   modport master (
      output start, signed_div, cancel, a, b,
      input  div_ready, result
   );

   modport slave (
      input  start, signed_div, cancel, a, b,
      output div_ready, result
   );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract, keep or restore.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             qbit_o
);
   logic [WIDTH:0] shl;
   logic [WIDTH:0] trial;

   assign shl    = {rem_i, bit_i};
   assign trial  = shl - {1'b0, dvs_i};
   // Negative trial (sign bit set) means the divisor did not fit: restore.
   assign qbit_o = ~trial[WIDTH];
   assign rem_o  = qbit_o ? trial[WIDTH-1:0] : shl[WIDTH-1:0];
endmodule

// File: rtl/div_unit.sv
// Iterative restoring DIV/DIVU: div_ready pulses WIDTH+1 cycles after launch, result = {rem, quo} held until next launch.
// No backpressure; cancel aborts. Optional DIV_ZERO_FAST_EN completes b==0 launches one cycle after launch.
module div_unit
   import cpu_defs_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic clk,
   input  logic rst,
   div_if.slave bus
);
   div_state_t           state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [WIDTH-1:0]     rem_q;
   logic [WIDTH-1:0]     dvd_q;
   logic [WIDTH-1:0]     dvs_q;
   logic                 neg_quo_q;
   logic                 neg_rem_q;
   logic                 ready_q;
   logic [2*WIDTH-1:0]   result_q;

   logic [WIDTH-1:0]     a_abs_d;
   logic [WIDTH-1:0]     b_abs_d;
   logic                 neg_quo_d;
   logic                 neg_rem_d;
   logic [WIDTH-1:0]     rem_d;
   logic                 qbit_d;
   logic [WIDTH-1:0]     quo_d;

   assign a_abs_d   = (bus.signed_div && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign b_abs_d   = (bus.signed_div && bus.b[WIDTH-1]) ? -bus.b : bus.b;
   assign neg_quo_d = bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
   assign neg_rem_d = bus.signed_div & bus.a[WIDTH-1];

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i  (rem_q),
      .bit_i  (dvd_q[WIDTH-1]),
      .dvs_i  (dvs_q),
      .rem_o  (rem_d),
      .qbit_o (qbit_d)
   );

   // Quotient bits shift into the vacated low end of the dividend register.
   assign quo_d = {dvd_q[WIDTH-2:0], qbit_d};

   function automatic logic [2*WIDTH-1:0] fixup(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r,
                                               input logic nq, input logic nr);
      logic [WIDTH-1:0] qf;
      logic [WIDTH-1:0] rf;
      qf = nq ? -q : q;
      rf = nr ? -r : r;
      return {rf, qf};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         ready_q   <= 1'b0;
         result_q  <= '0;
      end else if (bus.cancel) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               ready_q <= 1'b0;
               if (bus.start) begin
                  cnt_q     <= '0;
                  rem_q     <= '0;
                  dvd_q     <= a_abs_d;
                  dvs_q     <= b_abs_d;
                  neg_quo_q <= neg_quo_d;
                  neg_rem_q <= neg_rem_d;
`ifdef DIV_ZERO_FAST_EN
                  if (bus.b == '0) begin
                     state_q  <= DONE;
                     ready_q  <= 1'b1;
                     result_q <= fixup('1, a_abs_d, neg_quo_d, neg_rem_d);
                  end else begin
                     state_q <= BUSY;
                  end
`else
                  state_q <= BUSY;
`endif
               end
            end
            BUSY: begin
               rem_q <= rem_d;
               dvd_q <= quo_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_q  <= DONE;
                  ready_q  <= 1'b1;
                  result_q <= fixup(quo_d, rem_d, neg_quo_q, neg_rem_q);
               end
            end
            DONE: begin
               ready_q <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               ready_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.div_ready = ready_q;
   assign bus.result    = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed divides push {result, launch cycle, latency}; a monitor pops on div_ready.
module tb_div_unit;
   import cpu_defs_pkg::*;

`ifdef DIV_ZERO_FAST_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 33;
`endif
   localparam int LAT = 33;

   typedef struct {
      logic [63:0] res;
      int          cyc0;
      int          lat;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_pass;
   exp_t exp_q[$];
   logic [63:0] last_res;

   div_if #(.WIDTH(32)) bus ();

   div_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc++;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   // Monitor: every div_ready pulse must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.div_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_ready: got pulse at cycle %0d expected none", cyc);
            end else begin
               e = exp_q.pop_front();
               check64("result", bus.result, e.res);
               check64("latency", 64'(cyc - e.cyc0), 64'(e.lat));
            end
         end
      end
   end

   // Launch at a negedge (that cycle is cycle 0) and wait boundedly for the pulse.
   task automatic run_op(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eq, input logic [31:0] er,
                         input bit drop_early, input bit hold);
      exp_t e;
      bit   seen;
      @(negedge clk);
      bus.signed_div = sd;
      bus.a          = av;
      bus.b          = bv;
      bus.start      = 1'b1;
      e.res  = {er, eq};
      e.cyc0 = cyc;
      e.lat  = (bv == 32'd0) ? ZLAT : LAT;
      exp_q.push_back(e);
      seen = 1'b0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge clk);
         if (k == 1) begin
            bus.a = 32'hDEAD_BEEF;
            bus.b = 32'hDEAD_BEEF;
            bus.signed_div = ~sd;
         end
         if (drop_early && k == 3) bus.start = 1'b0;
         if (bus.div_ready === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (seen) n_pass++;
      else $display("FAIL ready_timeout: got no div_ready within 40 cycles expected %0d", e.lat);
      if (!hold) bus.start = 1'b0;
      last_res = {er, eq};
   endtask

   initial begin
      n_checks       = 0;
      n_pass         = 0;
      last_res       = '0;
      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.cancel     = 1'b0;
      bus.signed_div = 1'b0;
      bus.a          = '0;
      bus.b          = '0;
      repeat (3) @(negedge clk);
      check64("reset_ready", 64'(bus.div_ready), 64'd0);
      check64("reset_result", bus.result, 64'd0);
      rst = 1'b0;

      run_op(1'b0, 32'd100,       32'd7,        32'd14,        32'd2,         0, 0);
      run_op(1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD,  32'hFFFFFFFF,  0, 0);
      run_op(1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000,  32'd0,         0, 0);
      run_op(1'b0, 32'd5,         32'd0,        32'hFFFFFFFF,  32'd5,         0, 0);
      run_op(1'b1, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD,  32'd1,         0, 0);
      run_op(1'b1, 32'hFFFFFFF8,  32'd0,        32'd1,         32'hFFFFFFF8,  0, 0);
      run_op(1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'd14,        32'hFFFFFFFE,  1, 0);
      run_op(1'b0, 32'hFFFFFFFF,  32'd16,       32'h0FFFFFFF,  32'd15,        1, 0);
      // start held through DONE: next op launches only from the following IDLE cycle
      run_op(1'b0, 32'hFFFFFFFF,  32'd1,        32'hFFFFFFFF,  32'd0,         0, 1);
      run_op(1'b0, 32'd1000,      32'd1000,     32'd1,         32'd0,         0, 0);

      // cancel at cycle 10 of a DIVU
      @(negedge clk);
      bus.signed_div = 1'b0;
      bus.a = 32'd50;
      bus.b = 32'd3;
      bus.start = 1'b1;
      repeat (10) @(negedge clk);
      bus.cancel = 1'b1;
      bus.start  = 1'b0;
      @(negedge clk);
      bus.cancel = 1'b0;
      check64("cancel_ready", 64'(bus.div_ready), 64'd0);
      check64("cancel_result_kept", bus.result, last_res);
      // previous negedge left the FSM in IDLE, so this relaunch must still take the full latency
      run_op(1'b0, 32'd50, 32'd3, 32'd16, 32'd2, 0, 0);

      // cancel and start together: no launch
      @(negedge clk);
      bus.a = 32'd9;
      bus.b = 32'd2;
      bus.start  = 1'b1;
      bus.cancel = 1'b1;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      repeat (40) @(negedge clk);

      // reset mid-BUSY
      @(negedge clk);
      bus.a = 32'd77;
      bus.b = 32'd5;
      bus.start = 1'b1;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check64("rst_ready", 64'(bus.div_ready), 64'd0);
      check64("rst_result", bus.result, 64'd0);
      repeat (40) @(negedge clk);

      run_op(1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 0, 0);
      repeat (5) @(negedge clk);
      check64("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
